// File: rtl/dram_request_translator.sv
// Host request to DRAM command translator with per-bank open-row tracking.
// Ports: host req_* valid/ready in, issue FIFO push (o_issue_wen/o_cmd/o_bank/o_row/o_col) out,
// i_issue_full backpressure in, o_refresh_overrun pulse out.
package command_definition_pkg;
    localparam logic [2:0] CMD_NOP       = 3'd0;
    localparam logic [2:0] CMD_ACTIVE    = 3'd1;
    localparam logic [2:0] CMD_READ      = 3'd2;
    localparam logic [2:0] CMD_WRITE     = 3'd3;
    localparam logic [2:0] CMD_PRECHARGE = 3'd4;
    localparam logic [2:0] CMD_REFRESH   = 3'd5;
endpackage

module dram_request_translator
    import command_definition_pkg::*;
#(
    parameter int BA_BITS  = 3,
    parameter int ROW_BITS = 16,
    parameter int COL_BITS = 10,
    parameter int TREFI    = 7800,
    parameter int CMD_W    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [BA_BITS-1:0]  req_bank,
    input  logic [ROW_BITS-1:0] req_row,
    input  logic [COL_BITS-1:0] req_col,
    output logic                o_issue_wen,
    input  logic                i_issue_full,
    output logic [CMD_W-1:0]    o_cmd,
    output logic [BA_BITS-1:0]  o_bank,
    output logic [ROW_BITS-1:0] o_row,
    output logic [COL_BITS-1:0] o_col,
    output logic                o_refresh_overrun
);

    localparam int NUM_BANKS = 2 ** BA_BITS;
    localparam int CNT_W     = (TREFI > 1) ? $clog2(TREFI) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_MISS,
        S_ACT,
        S_RW,
        S_REF_PRE,
        S_REF
    } state_e;

    state_e               state_q, state_d;
    logic                 wr_q, wr_d;
    logic [BA_BITS-1:0]   bank_q, bank_d;
    logic [ROW_BITS-1:0]  row_q, row_d;
    logic [COL_BITS-1:0]  col_q, col_d;
    logic [BA_BITS-1:0]   bank_idx_q, bank_idx_d;

    logic [NUM_BANKS-1:0] open_vld_q;
    logic [ROW_BITS-1:0]  open_row_q [NUM_BANKS];

    logic [CNT_W-1:0]     refi_cnt_q, refi_cnt_d;
    logic                 ref_pending_q, ref_pending_d;
    logic                 overrun_q, overrun_d;
    logic                 expire;
    logic                 ref_done;

    logic                 wen_q, wen_d;
    logic [CMD_W-1:0]     cmd_q, cmd_d;
    logic [BA_BITS-1:0]   obank_q, obank_d;
    logic [ROW_BITS-1:0]  orow_q, orow_d;
    logic [COL_BITS-1:0]  ocol_q, ocol_d;

    assign req_ready         = (state_q == S_IDLE) && !ref_pending_q;
    assign o_issue_wen       = wen_q;
    assign o_cmd             = cmd_q;
    assign o_bank            = obank_q;
    assign o_row             = orow_q;
    assign o_col             = ocol_q;
    assign o_refresh_overrun = overrun_q;

    // A new expiry wins over a REF push in the same cycle, so the
    // freshly requested refresh is never lost.
    always_comb begin
        expire        = (refi_cnt_q == '0);
        refi_cnt_d    = expire ? CNT_W'(TREFI - 1) : refi_cnt_q - CNT_W'(1);
        overrun_d     = expire && ref_pending_q;
        ref_pending_d = ref_pending_q;
        if (expire) begin
            ref_pending_d = 1'b1;
        end else if (ref_done) begin
            ref_pending_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        bank_d     = bank_q;
        row_d      = row_q;
        col_d      = col_q;
        bank_idx_d = bank_idx_q;
        ref_done   = 1'b0;
        wen_d      = 1'b0;
        cmd_d      = CMD_W'(CMD_NOP);
        obank_d    = '0;
        orow_d     = '0;
        ocol_d     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (ref_pending_q) begin
                    state_d    = S_REF_PRE;
                    bank_idx_d = '0;
                end else if (req_valid) begin
                    wr_d   = req_write;
                    bank_d = req_bank;
                    row_d  = req_row;
                    col_d  = req_col;
                    if (!open_vld_q[req_bank]) begin
                        state_d = S_ACT;
                    end else if (open_row_q[req_bank] == req_row) begin
                        state_d = S_RW;
                    end else begin
                        state_d = S_PRE_MISS;
                    end
                end
            end
            S_PRE_MISS: begin
                if (!i_issue_full) begin
                    wen_d   = 1'b1;
                    cmd_d   = CMD_W'(CMD_PRECHARGE);
                    obank_d = bank_q;
                    state_d = S_ACT;
                end
            end
            S_ACT: begin
                if (!i_issue_full) begin
                    wen_d   = 1'b1;
                    cmd_d   = CMD_W'(CMD_ACTIVE);
                    obank_d = bank_q;
                    orow_d  = row_q;
                    state_d = S_RW;
                end
            end
            S_RW: begin
                if (!i_issue_full) begin
                    wen_d   = 1'b1;
                    cmd_d   = wr_q ? CMD_W'(CMD_WRITE) : CMD_W'(CMD_READ);
                    obank_d = bank_q;
                    ocol_d  = col_q;
                    state_d = S_IDLE;
                end
            end
            S_REF_PRE: begin
                // Closed banks are skipped without waiting on the FIFO.
                if (!open_vld_q[bank_idx_q] || !i_issue_full) begin
                    if (open_vld_q[bank_idx_q]) begin
                        wen_d   = 1'b1;
                        cmd_d   = CMD_W'(CMD_PRECHARGE);
                        obank_d = bank_idx_q;
                    end
                    if (&bank_idx_q) begin
                        state_d = S_REF;
                    end else begin
                        bank_idx_d = bank_idx_q + BA_BITS'(1);
                    end
                end
            end
            S_REF: begin
                if (!i_issue_full) begin
                    wen_d    = 1'b1;
                    cmd_d    = CMD_W'(CMD_REFRESH);
                    ref_done = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wr_q          <= 1'b0;
            bank_q        <= '0;
            row_q         <= '0;
            col_q         <= '0;
            bank_idx_q    <= '0;
            open_vld_q    <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                open_row_q[i] <= '0;
            end
            refi_cnt_q    <= CNT_W'(TREFI - 1);
            ref_pending_q <= 1'b0;
            overrun_q     <= 1'b0;
            wen_q         <= 1'b0;
            cmd_q         <= '0;
            obank_q       <= '0;
            orow_q        <= '0;
            ocol_q        <= '0;
        end else begin
            state_q       <= state_d;
            wr_q          <= wr_d;
            bank_q        <= bank_d;
            row_q         <= row_d;
            col_q         <= col_d;
            bank_idx_q    <= bank_idx_d;
            refi_cnt_q    <= refi_cnt_d;
            ref_pending_q <= ref_pending_d;
            overrun_q     <= overrun_d;
            wen_q         <= wen_d;
            cmd_q         <= cmd_d;
            obank_q       <= obank_d;
            orow_q        <= orow_d;
            ocol_q        <= ocol_d;
            // The table follows exactly what was pushed downstream.
            if (wen_d && cmd_d == CMD_W'(CMD_ACTIVE)) begin
                open_vld_q[obank_d] <= 1'b1;
                open_row_q[obank_d] <= orow_d;
            end else if (wen_d && cmd_d == CMD_W'(CMD_PRECHARGE)) begin
                open_vld_q[obank_d] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dram_request_translator.sv
// Self-checking bench for dram_request_translator.
// Queue-based command-stream reference model plus directed sequence checks.
module tb_dram_request_translator;
    import command_definition_pkg::*;

    localparam int NB    = 8;
    localparam int TREFI = 20;
    localparam int OW    = 1 + 3 + 3 + 16 + 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_bank = '0;
    logic [15:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic        o_issue_wen;
    logic        i_issue_full = 1'b0;
    logic [2:0]  o_cmd;
    logic [2:0]  o_bank;
    logic [15:0] o_row;
    logic [9:0]  o_col;
    logic        o_refresh_overrun;

    dram_request_translator #(
        .BA_BITS(3), .ROW_BITS(16), .COL_BITS(10), .TREFI(TREFI), .CMD_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
        .o_issue_wen(o_issue_wen), .i_issue_full(i_issue_full),
        .o_cmd(o_cmd), .o_bank(o_bank), .o_row(o_row), .o_col(o_col),
        .o_refresh_overrun(o_refresh_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        bubble;
        logic [2:0]  cmd;
        logic [2:0]  bank;
        logic [15:0] row;
        logic [9:0]  col;
    } slot_t;

    typedef struct {
        int          cyc;
        logic [2:0]  cmd;
        logic [2:0]  bank;
        logic [15:0] row;
        logic [9:0]  col;
    } push_t;

    slot_t       mq[$];
    push_t       seen[$];
    bit          m_vld[NB];
    logic [15:0] m_row[NB];
    bit          m_pend;
    int          m_cnt;
    logic [OW-1:0] exp_out;
    bit          exp_ovr, exp_ready, obs_ready;
    int          nassert = 0, nfail = 0, n_ovr = 0, cyc = 0;
    wire [OW-1:0] obs_out = {o_issue_wen, o_cmd, o_bank, o_row, o_col};

    function automatic slot_t mk(input logic [2:0] c, input logic [2:0] b,
                                 input logic [15:0] r, input logic [9:0] cl);
        slot_t s;
        s = '{bubble: 1'b0, cmd: c, bank: b, row: r, col: cl};
        return s;
    endfunction

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < NB; i++) begin
            m_vld[i] = 1'b0;
            m_row[i] = '0;
        end
        m_pend = 1'b0;
        m_cnt = TREFI - 1;
        exp_out = '0;
        exp_ovr = 1'b0;
    endfunction

    // One clock edge: the pending command stream advances by one slot.
    function automatic void model_edge(input bit v, input bit f, input bit w,
                                       input logic [2:0] b, input logic [15:0] r,
                                       input logic [9:0] c);
        bit pq;
        slot_t s;
        pq = m_pend;
        exp_out = '0;
        exp_ovr = 1'b0;
        if (mq.size() != 0) begin
            s = mq[0];
            if (s.bubble) begin
                s = mq.pop_front();
            end else if (!f) begin
                s = mq.pop_front();
                exp_out = {1'b1, s.cmd, s.bank, s.row, s.col};
                if (s.cmd == CMD_ACTIVE) begin
                    m_vld[s.bank] = 1'b1;
                    m_row[s.bank] = s.row;
                end else if (s.cmd == CMD_PRECHARGE) begin
                    m_vld[s.bank] = 1'b0;
                end else if (s.cmd == CMD_REFRESH) begin
                    m_pend = 1'b0;
                end
            end
        end else if (pq) begin
            for (int i = 0; i < NB; i++) begin
                s = mk(CMD_PRECHARGE, 3'(i), '0, '0);
                s.bubble = !m_vld[i];
                mq.push_back(s);
            end
            mq.push_back(mk(CMD_REFRESH, '0, '0, '0));
        end else if (v) begin
            if (!(m_vld[b] && m_row[b] == r)) begin
                if (m_vld[b]) mq.push_back(mk(CMD_PRECHARGE, b, '0, '0));
                mq.push_back(mk(CMD_ACTIVE, b, r, '0));
            end
            mq.push_back(mk(w ? CMD_WRITE : CMD_READ, b, '0, c));
        end
        if (m_cnt == 0) begin
            m_cnt = TREFI - 1;
            exp_ovr = pq;
            m_pend = 1'b1;
        end else begin
            m_cnt--;
        end
    endfunction

    task automatic tick(input bit v, input bit f, input bit w, input logic [2:0] b,
                        input logic [15:0] r, input logic [9:0] c);
        req_valid = v;
        i_issue_full = f;
        req_write = w;
        req_bank = b;
        req_row = r;
        req_col = c;
        #1;
        exp_ready = (mq.size() == 0) && !m_pend;
        obs_ready = req_ready;
        @(posedge clk);
        cyc++;
        model_edge(v, f, w, b, r, c);
        @(negedge clk);
        if (o_issue_wen) seen.push_back('{cyc, o_cmd, o_bank, o_row, o_col});
        if (o_refresh_overrun) n_ovr++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        i_issue_full = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        cyc = 0;
        n_ovr = 0;
        seen.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        if (req_ready !== 1'b1) begin nfail++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        if (obs_out !== '0) begin nfail++; $display("FAIL reset_out got %h exp 0", obs_out); end
        if (o_refresh_overrun !== 1'b0) begin nfail++; $display("FAIL reset_ovr got %b exp 0", o_refresh_overrun); end
        nassert += 3;
    endtask

    task automatic test_empty_read();
        for (int i = 0; i < 4; i++) begin
            tick(i == 0, 0, 0, 3'd2, 16'h10, 10'd5);
            if (obs_ready !== exp_ready) begin nfail++; $display("FAIL empty_ready c%0d got %b exp %b", cyc, obs_ready, exp_ready); end
            if (obs_out !== exp_out) begin nfail++; $display("FAIL empty_push c%0d got %h exp %h", cyc, obs_out, exp_out); end
            if (o_refresh_overrun !== exp_ovr) begin nfail++; $display("FAIL empty_ovr c%0d got %b exp %b", cyc, o_refresh_overrun, exp_ovr); end
            nassert += 3;
        end
        if (seen.size() != 2 || seen[0].cmd !== CMD_ACTIVE || seen[0].bank !== 3'd2
            || seen[0].row !== 16'h10 || seen[1].cmd !== CMD_READ || seen[1].bank !== 3'd2
            || seen[1].col !== 10'd5 || seen[0].cyc != 2 || seen[1].cyc != 3) begin
            nfail++;
            $display("FAIL empty_seq got n=%0d c0=%0d c1=%0d exp ACT@2 RD@3", seen.size(), seen[0].cmd, seen[1].cmd);
        end
        if (req_ready !== 1'b1) begin nfail++; $display("FAIL empty_ready_after got %b exp 1", req_ready); end
        nassert += 2;
    endtask

    task automatic test_hit_write();
        seen.delete();
        for (int i = 0; i < 3; i++) begin
            tick(i == 0, 0, 1, 3'd2, 16'h10, 10'd9);
            if (obs_ready !== exp_ready) begin nfail++; $display("FAIL hit_ready c%0d got %b exp %b", cyc, obs_ready, exp_ready); end
            if (obs_out !== exp_out) begin nfail++; $display("FAIL hit_push c%0d got %h exp %h", cyc, obs_out, exp_out); end
            if (o_refresh_overrun !== exp_ovr) begin nfail++; $display("FAIL hit_ovr c%0d got %b exp %b", cyc, o_refresh_overrun, exp_ovr); end
            nassert += 3;
        end
        if (seen.size() != 1 || seen[0].cmd !== CMD_WRITE || seen[0].col !== 10'd9 || seen[0].cyc != 6) begin
            nfail++;
            $display("FAIL hit_seq got n=%0d cmd=%0d cyc=%0d exp WR@6", seen.size(), seen[0].cmd, seen[0].cyc);
        end
        nassert++;
    endtask

    task automatic test_conflict();
        seen.delete();
        for (int i = 0; i < 8; i++) begin
            tick(i == 0 || i == 5, 0, 0, 3'd2, 16'h20, i == 0 ? 10'd7 : 10'd1);
            if (obs_ready !== exp_ready) begin nfail++; $display("FAIL conf_ready c%0d got %b exp %b", cyc, obs_ready, exp_ready); end
            if (obs_out !== exp_out) begin nfail++; $display("FAIL conf_push c%0d got %h exp %h", cyc, obs_out, exp_out); end
            if (o_refresh_overrun !== exp_ovr) begin nfail++; $display("FAIL conf_ovr c%0d got %b exp %b", cyc, o_refresh_overrun, exp_ovr); end
            nassert += 3;
        end
        // Trailing request to row 0x20 must now be a plain hit.
        if (seen.size() != 4 || seen[0].cmd !== CMD_PRECHARGE || seen[1].cmd !== CMD_ACTIVE
            || seen[1].row !== 16'h20 || seen[2].cmd !== CMD_READ || seen[2].col !== 10'd7
            || seen[3].cmd !== CMD_READ || seen[3].col !== 10'd1) begin
            nfail++;
            $display("FAIL conf_seq got n=%0d %0d %0d %0d exp PRE ACT RD RD", seen.size(), seen[0].cmd, seen[1].cmd, seen[2].cmd);
        end
        nassert++;
    endtask

    task automatic test_refresh();
        logic [2:0] ec [9];
        logic [2:0] eb [9];
        bit ok;
        ec = '{CMD_ACTIVE, CMD_READ, CMD_ACTIVE, CMD_READ, CMD_PRECHARGE,
               CMD_PRECHARGE, CMD_REFRESH, CMD_ACTIVE, CMD_READ};
        eb = '{3'd1, 3'd1, 3'd3, 3'd3, 3'd1, 3'd3, 3'd0, 3'd1, 3'd1};
        do_reset();
        for (int i = 1; i <= 38; i++) begin
            tick(i == 1 || i == 4 || i == 32, 0, 0, (i == 4) ? 3'd3 : 3'd1, 16'h44, 10'd2);
            if (obs_ready !== exp_ready) begin nfail++; $display("FAIL ref_ready c%0d got %b exp %b", cyc, obs_ready, exp_ready); end
            if (obs_out !== exp_out) begin nfail++; $display("FAIL ref_push c%0d got %h exp %h", cyc, obs_out, exp_out); end
            if (o_refresh_overrun !== exp_ovr) begin nfail++; $display("FAIL ref_ovr c%0d got %b exp %b", cyc, o_refresh_overrun, exp_ovr); end
            nassert += 3;
        end
        ok = (seen.size() == 9);
        for (int i = 0; i < 9; i++) begin
            if (i < seen.size() && (seen[i].cmd !== ec[i] || seen[i].bank !== eb[i])) ok = 0;
        end
        if (!ok || seen[6].cyc != 30) begin
            nfail++;
            $display("FAIL ref_seq got n=%0d ref@%0d exp 9 pushes with REF@30", seen.size(), seen[6].cyc);
        end
        nassert++;
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            tick(i == 1, i >= 2 && i <= 6, 0, 3'd5, 16'h7, 10'd3);
            if (obs_ready !== exp_ready) begin nfail++; $display("FAIL full_ready c%0d got %b exp %b", cyc, obs_ready, exp_ready); end
            if (obs_out !== exp_out) begin nfail++; $display("FAIL full_push c%0d got %h exp %h", cyc, obs_out, exp_out); end
            if (o_refresh_overrun !== exp_ovr) begin nfail++; $display("FAIL full_ovr c%0d got %b exp %b", cyc, o_refresh_overrun, exp_ovr); end
            nassert += 3;
        end
        if (seen.size() != 2 || seen[0].cmd !== CMD_ACTIVE || seen[0].cyc != 7
            || seen[1].cmd !== CMD_READ || seen[1].cyc != 8) begin
            nfail++;
            $display("FAIL full_seq got n=%0d act@%0d rd@%0d exp ACT@7 RD@8", seen.size(), seen[0].cyc, seen[1].cyc);
        end
        nassert++;
    endtask

    task automatic test_overrun();
        do_reset();
        for (int i = 1; i <= 85; i++) begin
            tick(0, i <= 70, 0, 3'd0, 16'h0, 10'd0);
            if (obs_ready !== exp_ready) begin nfail++; $display("FAIL ovr_ready c%0d got %b exp %b", cyc, obs_ready, exp_ready); end
            if (obs_out !== exp_out) begin nfail++; $display("FAIL ovr_push c%0d got %h exp %h", cyc, obs_out, exp_out); end
            if (o_refresh_overrun !== exp_ovr) begin nfail++; $display("FAIL ovr_pulse c%0d got %b exp %b", cyc, o_refresh_overrun, exp_ovr); end
            nassert += 3;
        end
        if (n_ovr != 2) begin nfail++; $display("FAIL ovr_count got %0d exp 2", n_ovr); end
        nassert++;
    endtask

    task automatic test_midreset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(i == 0 || i == 3, 0, 0, 3'd4, (i == 0) ? 16'h1 : 16'h2, 10'd3);
            if (obs_out !== exp_out) begin nfail++; $display("FAIL mid_push c%0d got %h exp %h", cyc, obs_out, exp_out); end
            nassert++;
        end
        #2 rst_n = 1'b0;
        #1;
        if (obs_out !== '0 || req_ready !== 1'b1) begin
            nfail++;
            $display("FAIL mid_async got out=%h rdy=%b exp 0/1", obs_out, req_ready);
        end
        nassert++;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        cyc = 0;
        seen.delete();
        for (int i = 0; i < 4; i++) begin
            tick(i == 0, 0, 0, 3'd4, 16'h2, 10'd3);
            if (obs_out !== exp_out) begin nfail++; $display("FAIL mid_after c%0d got %h exp %h", cyc, obs_out, exp_out); end
            nassert++;
        end
        if (seen.size() != 2 || seen[0].cmd !== CMD_ACTIVE) begin
            nfail++;
            $display("FAIL mid_table got n=%0d first=%0d exp ACT first", seen.size(), seen[0].cmd);
        end
        nassert++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 3'($urandom), 16'($urandom_range(0, 2)), 10'($urandom));
            if (obs_ready !== exp_ready) begin nfail++; $display("FAIL rnd_ready c%0d got %b exp %b", cyc, obs_ready, exp_ready); end
            if (obs_out !== exp_out) begin nfail++; $display("FAIL rnd_push c%0d got %h exp %h", cyc, obs_out, exp_out); end
            if (o_refresh_overrun !== exp_ovr) begin nfail++; $display("FAIL rnd_ovr c%0d got %b exp %b", cyc, o_refresh_overrun, exp_ovr); end
            nassert += 3;
        end
    endtask

    initial begin
        test_reset();
        test_empty_read();
        test_hit_write();
        test_conflict();
        test_refresh();
        test_full_stall();
        test_overrun();
        test_midreset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule

// File: doc/dram_request_translator.md
Name: dram_request_translator

Overview:
- Upstream neighbour of the command scheduler.
- Converts host read/write requests (bank, row, column) into the ACT/RD/WR/PRE command sequence the scheduler consumes, and writes that sequence into the issue FIFO.
- Tracks the open row of every bank, so row hits skip ACT and row conflicts insert PRE.
- Inserts periodic REFRESH, preceded by PRE to every open bank. Does not enforce DRAM timing; the scheduler does that.

Parameters:
- BA_BITS, 3, bank address width; NUM_BANKS = 2**BA_BITS.
- ROW_BITS, 16, row address width.
- COL_BITS, 10, column address width.
- TREFI, 7800, cycles between refresh requests.
- CMD_W, 3, width of the command code (values from command_definition_pkg).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- req_valid  in  1  host request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_bank  in  BA_BITS  target bank.
- req_row  in  ROW_BITS  target row.
- req_col  in  COL_BITS  target column.
- o_issue_wen  out  1  issue FIFO push strobe.
- i_issue_full  in  1  issue FIFO full.
- o_cmd  out  CMD_W  CMD_ACTIVE / CMD_READ / CMD_WRITE / CMD_PRECHARGE / CMD_REFRESH.
- o_bank  out  BA_BITS  command bank.
- o_row  out  ROW_BITS  row (ACT); 0 otherwise.
- o_col  out  COL_BITS  column (RD/WR); 0 otherwise.
- o_refresh_overrun  out  1  one-cycle pulse: TREFI expired while a refresh was still pending.

Behaviour:
- Reset rst_n, asynchronous, active-low; clock clk. All state is on posedge clk.
- Reset values: state = IDLE; open-row table all invalid; refi_cnt = TREFI-1; ref_pending = 0; o_issue_wen = 0; o_cmd/o_bank/o_row/o_col = 0; o_refresh_overrun = 0.
- req_ready = (state == IDLE) && !ref_pending. It is combinational and is 1 immediately after reset.
- Refresh counter: refi_cnt decrements every cycle. At 0 it reloads TREFI-1 and sets ref_pending. If ref_pending is already 1 at that moment, o_refresh_overrun pulses and ref_pending stays 1. ref_pending clears in the cycle the REF is pushed.
- Push rule: every command-issuing state asserts o_issue_wen with its fields only when !i_issue_full. Otherwise o_issue_wen = 0 and the state holds. At most one push per cycle.
- Outputs are registered: the push appears the cycle after the decision.
- Accepting a request latches write/bank/row/col.
- Open-row table: one entry per bank (valid + row). A pushed ACT sets valid and row. A pushed PRE clears valid.
- IDLE:
  - ref_pending -> REF_PRE (refresh has priority over req_valid in the same cycle). bank_idx = 0.
  - Else, on accept:
    - Hit (valid && row match) -> RW.
    - Empty (!valid) -> ACT.
    - Conflict (valid && row mismatch) -> PRE_MISS.
- PRE_MISS: push PRE (latched bank) -> ACT.
- ACT: push ACT (bank, row) -> RW.
- RW: push RD or WR (bank, col) -> IDLE.
- REF_PRE: examines bank_idx each cycle.
  - Valid: push PRE (bank_idx).
  - Invalid: skip with no push, one cycle per bank.
  - After bank NUM_BANKS-1 is handled -> REF.
- REF: push REFRESH (o_bank = 0) -> IDLE.
- Latency from accept (cycle 0), FIFO never full:
  - Hit: RD/WR pushed in cycle 1.
  - Empty: ACT in cycle 1, RD/WR in cycle 2.
  - Conflict: PRE in cycle 1, ACT in cycle 2, RD/WR in cycle 3.
- Sequence order is never altered by FIFO backpressure; pushes stall in place.
- Mid-sequence reset: asynchronously returns every register to its reset value. The latched request is dropped and the table is invalid.

Test Plan:
- Reset, then read bank 2 row 0x10 col 5 -> pushes ACT(b2, r0x10) then RD(b2, c5) on consecutive cycles; req_ready returns 1 afterwards.
- Same bank/row write col 9 -> single WR(b2, c9) one cycle after accept; no ACT.
- Read bank 2 row 0x20 -> PRE(b2), ACT(b2, r0x20), RD in order; table row for b2 = 0x20.
- TREFI = 20 with banks 1 and 3 open -> req_ready drops; PRE(b1), PRE(b3), REFRESH pushed; banks 0/2/4-7 are skipped with no push; table is all invalid afterwards.
- i_issue_full held high for 5 cycles during the ACT state -> no push while full; ACT pushed the cycle after full drops, then RD; no command is lost or duplicated.
- i_issue_full held high longer than TREFI while a refresh is pending -> o_refresh_overrun pulses exactly once per expiry.
